// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet PCS/PMA link controller.
package eth_pkg;

    typedef enum logic [1:0] {
        S_HOLD,
        S_AN_WAIT,
        S_RESTART,
        S_LINK_UP
    } link_state_t;

    // Bit positions inside the PCS/PMA status_vector
    localparam int SV_LINK_STATUS = 0;
    localparam int SV_LINK_SYNC   = 1;
    localparam int SV_SPEED_LO    = 10;
    localparam int SV_SPEED_HI    = 11;
    localparam int SV_DUPLEX      = 12;

    localparam logic [1:0] SPEED_10   = 2'b00;
    localparam logic [1:0] SPEED_100  = 2'b01;
    localparam logic [1:0] SPEED_1000 = 2'b10;

    localparam logic [15:0] ADV_SGMII     = 16'hD801;
    localparam logic [15:0] ADV_1000BASEX = 16'h0020;

    // Width needed to hold 0..max_val, never less than one bit
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/eth_link_debounce.sv
// Level debouncer: out follows in only after in has differed from out for
// DEBOUNCE_CYCLES consecutive cycles; clear forces out low.
module eth_link_debounce
    import eth_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1250
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic in,
    output logic out
);

    localparam int            CW   = cnt_width(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] count;

    // NOTE: reset is sampled on the clock edge and every state update uses <=
    // so all flops see pre-edge values regardless of block ordering.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            out   <= 1'b0;
            count <= '0;
        end else if (in == out) begin
            count <= '0;
        end else if (count == LAST) begin
            out   <= in;
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/eth_pcspma_link_ctrl.sv
// Link/autonegotiation supervisor for a 1G PCS/PMA core.
// Define ETH_LINK_STATS_EN to add saturating link-up and AN-restart counters.
module eth_pcspma_link_ctrl
    import eth_pkg::*;
#(
    parameter int SGMII_MODE           = 1,
    parameter int AN_TIMEOUT_CYCLES    = 125000000,
    parameter int DEBOUNCE_CYCLES      = 1250,
    parameter int RESTART_PULSE_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pma_reset_out,
    input  logic [15:0] status_vector,
    input  logic        an_interrupt,
    input  logic        isolate_req,
    output logic [4:0]  configuration_vector,
    output logic [15:0] an_adv_config_vector,
    output logic        an_restart_config,
    output logic        speed_is_10_100,
    output logic        speed_is_100,
    output logic        signal_detect,
    output logic        link_up,
`ifdef ETH_LINK_STATS_EN
    output logic [15:0] link_up_count,
    output logic [15:0] an_restart_count,
`endif
    output logic        link_change_irq
);

    localparam int            TW           = cnt_width(AN_TIMEOUT_CYCLES - 1);
    localparam int            RW           = cnt_width(RESTART_PULSE_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_LAST   = TW'(AN_TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RESTART_LAST = RW'(RESTART_PULSE_CYCLES - 1);

    link_state_t   state;
    logic [TW-1:0] timer;
    logic [RW-1:0] restart_cnt;
    logic [1:0]    speed_latched;
    logic [1:0]    speed_in;
    logic          an_int_d, link_up_d, isolate_q;
    logic          deb_in, deb_out, deb_clear, an_int_rise;
    logic          unused_status;

    // Up-detection needs sync as well as link; once up, only link_status matters
    assign deb_in      = (state == S_LINK_UP) ? status_vector[SV_LINK_STATUS]
                       : (status_vector[SV_LINK_STATUS] & status_vector[SV_LINK_SYNC]);
    assign deb_clear   = (state == S_HOLD) || (state == S_RESTART);
    assign an_int_rise = an_interrupt & ~an_int_d;
    assign speed_in    = (status_vector[SV_SPEED_HI:SV_SPEED_LO] == 2'b11) ? SPEED_1000
                       : status_vector[SV_SPEED_HI:SV_SPEED_LO];
    assign unused_status = ^{status_vector[15:SV_DUPLEX], status_vector[9:2]};

    eth_link_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock(clock),
        .reset(reset),
        .clear(deb_clear),
        .in   (deb_in),
        .out  (deb_out)
    );

    always_ff @(posedge clock) begin
        if (reset || pma_reset_out) begin
            state             <= S_HOLD;
            timer             <= '0;
            restart_cnt       <= '0;
            speed_latched     <= SPEED_1000;
            link_up           <= 1'b0;
            an_restart_config <= 1'b0;
        end else begin
            case (state)
                S_HOLD: begin
                    state <= S_AN_WAIT;
                    timer <= '0;
                end
                S_AN_WAIT: begin
                    if (deb_out) begin
                        state         <= S_LINK_UP;
                        link_up       <= 1'b1;
                        speed_latched <= speed_in;
                    end else if (an_int_rise) begin
                        timer <= '0;
                    end else if (timer == TIMER_LAST) begin
                        state             <= S_RESTART;
                        restart_cnt       <= '0;
                        an_restart_config <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_RESTART: begin
                    if (restart_cnt == RESTART_LAST) begin
                        state             <= S_AN_WAIT;
                        timer             <= '0;
                        restart_cnt       <= '0;
                        an_restart_config <= 1'b0;
                    end else begin
                        restart_cnt <= restart_cnt + 1'b1;
                    end
                end
                S_LINK_UP: begin
                    if (!deb_out) begin
                        state         <= S_AN_WAIT;
                        timer         <= '0;
                        link_up       <= 1'b0;
                        speed_latched <= SPEED_1000;
                    end
                end
                default: state <= S_HOLD;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            an_int_d        <= 1'b0;
            link_up_d       <= 1'b0;
            link_change_irq <= 1'b0;
            isolate_q       <= 1'b0;
            speed_is_10_100 <= 1'b0;
            speed_is_100    <= 1'b0;
        end else begin
            an_int_d        <= an_interrupt;
            link_up_d       <= link_up;
            link_change_irq <= link_up ^ link_up_d;
            isolate_q       <= isolate_req;
            speed_is_10_100 <= (speed_latched != SPEED_1000);
            speed_is_100    <= (speed_latched == SPEED_100);
        end
    end

    assign configuration_vector = {1'b1, isolate_q, 3'b000};
    assign an_adv_config_vector = (SGMII_MODE != 0) ? ADV_SGMII : ADV_1000BASEX;
    assign signal_detect        = 1'b1;

`ifdef ETH_LINK_STATS_EN
    logic restart_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            restart_d        <= 1'b0;
            link_up_count    <= '0;
            an_restart_count <= '0;
        end else begin
            restart_d <= an_restart_config;
            if (link_up && !link_up_d && link_up_count != 16'hFFFF)
                link_up_count <= link_up_count + 16'd1;
            if (an_restart_config && !restart_d && an_restart_count != 16'hFFFF)
                an_restart_count <= an_restart_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_eth_pcspma_link_ctrl.sv
// Self-checking bench for eth_pcspma_link_ctrl (short timeouts, directed vectors).
module tb_eth_pcspma_link_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        pma_reset_out;
    logic [15:0] status_vector;
    logic        an_interrupt;
    logic        isolate_req;
    logic [4:0]  configuration_vector;
    logic [15:0] an_adv_config_vector;
    logic        an_restart_config;
    logic        speed_is_10_100;
    logic        speed_is_100;
    logic        signal_detect;
    logic        link_up;
    logic        link_change_irq;
`ifdef ETH_LINK_STATS_EN
    logic [15:0] link_up_count;
    logic [15:0] an_restart_count;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clock = ~clock;

    eth_pcspma_link_ctrl #(
        .SGMII_MODE          (1),
        .AN_TIMEOUT_CYCLES   (1000),
        .DEBOUNCE_CYCLES     (8),
        .RESTART_PULSE_CYCLES(4)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .pma_reset_out       (pma_reset_out),
        .status_vector       (status_vector),
        .an_interrupt        (an_interrupt),
        .isolate_req         (isolate_req),
        .configuration_vector(configuration_vector),
        .an_adv_config_vector(an_adv_config_vector),
        .an_restart_config   (an_restart_config),
        .speed_is_10_100     (speed_is_10_100),
        .speed_is_100        (speed_is_100),
        .signal_detect       (signal_detect),
        .link_up             (link_up),
`ifdef ETH_LINK_STATS_EN
        .link_up_count       (link_up_count),
        .an_restart_count    (an_restart_count),
`endif
        .link_change_irq     (link_change_irq)
    );

    typedef struct {
        logic        pma;
        logic [15:0] sv;
        logic        iso;
        int          cyc;
        logic [9:0]  exp;
    } vec_t;

    vec_t vecs [13];

    // {link_up, irq, speed_is_10_100, speed_is_100, iso} -> packed output image
    function automatic logic [9:0] exp_of(input logic [4:0] b);
        return {b[4], b[3], b[2], b[1], 1'b1, b[0], 3'b000, 1'b0};
    endfunction

    function automatic logic [9:0] outs();
        return {link_up, link_change_irq, speed_is_10_100, speed_is_100,
                configuration_vector, an_restart_config};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Steps until an_restart_config is seen high or the bound expires
    task automatic wait_restart(input int bound, output int n);
        n = 0;
        while (n < bound) begin
            step(1);
            n++;
            if (an_restart_config) break;
        end
    endtask

    task automatic fresh_start();
        pma_reset_out = 1'b1;
        step(2);
        pma_reset_out = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n, w;
        logic seen;

        vecs[0]  = '{1'b1, 16'h0000, 1'b0, 2, exp_of(5'b00000)};
        vecs[1]  = '{1'b0, 16'h0803, 1'b0, 9, exp_of(5'b00000)};
        vecs[2]  = '{1'b0, 16'h0803, 1'b0, 1, exp_of(5'b10000)};
        vecs[3]  = '{1'b0, 16'h0803, 1'b0, 1, exp_of(5'b11000)};
        vecs[4]  = '{1'b0, 16'h0803, 1'b1, 1, exp_of(5'b10001)};
        vecs[5]  = '{1'b0, 16'h0000, 1'b0, 8, exp_of(5'b10000)};
        vecs[6]  = '{1'b0, 16'h0000, 1'b0, 1, exp_of(5'b00000)};
        vecs[7]  = '{1'b0, 16'h0000, 1'b0, 1, exp_of(5'b01000)};
        vecs[8]  = '{1'b0, 16'h0403, 1'b0, 8, exp_of(5'b00000)};
        vecs[9]  = '{1'b0, 16'h0403, 1'b0, 1, exp_of(5'b10000)};
        vecs[10] = '{1'b0, 16'h0403, 1'b0, 1, exp_of(5'b11110)};
        vecs[11] = '{1'b0, 16'h0400, 1'b0, 9, exp_of(5'b00110)};
        vecs[12] = '{1'b0, 16'h0400, 1'b0, 1, exp_of(5'b01000)};

        reset         = 1'b1;
        pma_reset_out = 1'b1;
        status_vector = 16'h0000;
        an_interrupt  = 1'b0;
        isolate_req   = 1'b0;
        step(3);
        reset = 1'b0;
        check("reset_state", 32'(outs()), 32'(exp_of(5'b00000)));
        check("adv_config", 32'(an_adv_config_vector), 32'h0000D801);
        check("signal_detect", 32'(signal_detect), 32'd1);

        // Link up at 1000, isolate, drop, link up at 100, drop
        for (int i = 0; i < 13; i++) begin
            pma_reset_out = vecs[i].pma;
            status_vector = vecs[i].sv;
            isolate_req   = vecs[i].iso;
            step(vecs[i].cyc);
            check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
        end

        // AN timeout: pulse width 4 at timer 999, period 1004
        status_vector = 16'h0000;
        fresh_start();
        wait_restart(1100, n);
        check("restart_first_delay", 32'(n), 32'd1001);
        w = 1;
        while (w < 20) begin
            step(1);
            if (!an_restart_config) break;
            w++;
        end
        check("restart_width", 32'(w), 32'd4);
        wait_restart(1100, n);
        check("restart_period", 32'(w + n), 32'd1004);

        // Reset in the middle of the restart pulse
        step(1);
        reset = 1'b1;
        step(1);
        check("restart_cut_by_reset", 32'(an_restart_config), 32'd0);
        reset = 1'b0;

        // A rising an_interrupt edge restarts the timeout; the held level does not
        fresh_start();
        step(500);
        an_interrupt = 1'b1;
        wait_restart(1100, n);
        check("an_irq_delays_restart", 32'(n), 32'd1001);
        an_interrupt = 1'b0;

        // Glitchy link never qualifies; then speed 11 latches as 1000
        fresh_start();
        step(1);
        seen = 1'b0;
        for (int r = 0; r < 6; r++) begin
            status_vector = 16'h0003;
            for (int k = 0; k < 5; k++) begin
                step(1);
                seen |= link_up;
            end
            status_vector = 16'h0000;
            step(1);
            seen |= link_up;
        end
        check("glitch_no_link", 32'(seen), 32'd0);
        status_vector = 16'h0C03;
        step(10);
        check("speed11_as_1000", 32'({link_up, link_change_irq, speed_is_10_100, speed_is_100}),
              32'b1100);
`ifdef ETH_LINK_STATS_EN
        check("link_up_count_1", 32'(link_up_count), 32'd1);
        check("an_restart_count", 32'(an_restart_count), 32'd1);
`endif

        // PMA reset while linked drops link_up immediately
        pma_reset_out = 1'b1;
        step(1);
        check("pma_drop_link", 32'(link_up), 32'd0);
        step(1);
        check("pma_drop_irq", 32'(link_change_irq), 32'd1);
        pma_reset_out = 1'b0;
        status_vector = 16'h0803;
        step(12);
        check("relink_after_pma", 32'(link_up), 32'd1);
`ifdef ETH_LINK_STATS_EN
        check("link_up_count_2", 32'(link_up_count), 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
